seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 193 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD converter feeding a multiplexed 7-segment scan driver with leading-zero blanking.
// Latency: display registers update DATA_W+1 cycles after the load-accepting edge.
// Backpressure: load is ignored while busy is high; nothing is queued.
module seg7_scan_driver #(
   parameter int DATA_W      = 16,
   parameter int NUM_DIGITS  = 5,
   parameter int REFRESH_DIV = 1000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_W-1:0]     value,
   output logic                  busy,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic [0:6]            segmentcode
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int k = 0; k < n; k++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

   function automatic logic [0:6] encode(input logic [3:0] d);
      logic [0:6] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

   state_t                state, state_nxt;
   logic [DATA_W-1:0]     bin_q;
   logic [BCD_W-1:0]      bcd_q, bcd_adj;
   logic                  ovf_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [BCD_W-1:0]      disp_q, disp_nxt;
   logic                  disp_ovf_q, disp_ovf_nxt;
   logic [PRE_W-1:0]      presc_q;
   logic                  presc_last;
   logic [IDX_W-1:0]      idx_q, idx_nxt;
   logic [NUM_DIGITS-1:0] en_nxt;
   logic [0:6]            seg_nxt;
   logic                  too_big;

   assign too_big  = (64'(value) >= LIMIT);
   assign busy     = (state != IDLE);
   assign overflow = disp_ovf_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept load only in IDLE, convert for DATA_W cycles, one cycle to publish
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = CONVERT;
         CONVERT: if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
   end

   // Double-dabble datapath: capture, then shift one binary bit MSB-first per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (state == IDLE) begin
         if (load) begin
            bin_q <= value;
            bcd_q <= '0;
            ovf_q <= too_big;
            cnt_q <= '0;
         end
      end else if (state == CONVERT) begin
         bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
         bin_q <= bin_q << 1;
         ovf_q <= ovf_q | bcd_adj[BCD_W-1];
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Display contents as they will be after this edge, so segments track new results immediately
   always_comb begin
      disp_nxt     = disp_q;
      disp_ovf_nxt = disp_ovf_q;
      if (state == UPDATE) begin
         disp_nxt     = bcd_q;
         disp_ovf_nxt = ovf_q;
      end
   end

   // Display registers, written only from the UPDATE state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
      end else begin
         disp_q     <= disp_nxt;
         disp_ovf_q <= disp_ovf_nxt;
      end
   end

   // Scan index advance on the prescaler terminal count
   always_comb begin
      presc_last = (presc_q == PRE_W'(REFRESH_DIV - 1));
      idx_nxt    = idx_q;
      if (presc_last) begin
         idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      en_nxt = NUM_DIGITS'(1) << idx_nxt;
   end

   // Segment pattern for the digit selected next: dash on overflow, blank for leading zeros
   always_comb begin
      logic [3:0] digit;
      logic       blank;
      digit = 4'd0;
      blank = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx_nxt == IDX_W'(d)) begin
            digit = disp_nxt[4*d +: 4];
            blank = (BLANK_LZ != 0) && (d > 0) && ((disp_nxt >> (4 * d)) == '0);
         end
      end
      if (disp_ovf_nxt) begin
         seg_nxt = 7'b0000001;
      end else if (blank) begin
         seg_nxt = 7'b0000000;
      end else begin
         seg_nxt = encode(digit);
      end
   end

   // Free-running scan: prescaler, digit index, and the registered digit/segment pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         idx_q       <= '0;
         digit_en    <= NUM_DIGITS'(1);
         segmentcode <= 7'b1111110;
      end else begin
         presc_q     <= presc_last ? '0 : presc_q + PRE_W'(1);
         idx_q       <= idx_nxt;
         digit_en    <= en_nxt;
         segmentcode <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (5 digits blanked, 5 digits unblanked, 4 digits)
// share clock, reset and load/value; each is compared every cycle to a value-level model.
// Directed scenarios first, then randomized loads, then a reset in the middle of a conversion.
module tb_seg7_scan_driver;

   localparam int DW = 16;
   localparam int RD = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          load  = 1'b0;
   logic [DW-1:0] value = '0;

   logic       busy5, ovf5, busyn, ovfn, busy4, ovf4;
   logic [4:0] en5, enn;
   logic [3:0] en4;
   logic [0:6] seg5, segn, seg4;

   always #5 clk = ~clk;

   seg7_scan_driver #(.DATA_W(DW), .NUM_DIGITS(5), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy5),
      .overflow(ovf5), .digit_en(en5), .segmentcode(seg5));

   seg7_scan_driver #(.DATA_W(DW), .NUM_DIGITS(5), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_dutn (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busyn),
      .overflow(ovfn), .digit_en(enn), .segmentcode(segn));

   seg7_scan_driver #(.DATA_W(DW), .NUM_DIGITS(4), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy4),
      .overflow(ovf4), .digit_en(en4), .segmentcode(seg4));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [0:6] enc(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   // Expected pattern on digit i for a displayed decimal value
   function automatic logic [0:6] exp_seg(input int v, input int i, input int nd, input bit blz);
      if (v >= pow10(nd)) return 7'b0000001;
      if (blz && i > 0 && v < pow10(i)) return 7'b0000000;
      return enc((v / pow10(i)) % 10);
   endfunction

   // Reference model: edges since reset, remaining busy cycles, pending and shown values
   int m_cycles = 0;
   int m_left   = 0;
   int m_pend   = 0;
   int m_shown  = 0;
   bit chk_on   = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_cycles = 0;
            m_left   = 0;
            m_pend   = 0;
            m_shown  = 0;
         end else begin
            m_cycles++;
            if (m_left == 0) begin
               if (load) begin
                  m_pend = int'(value);
                  m_left = DW + 1;
               end
            end else begin
               m_left--;
               if (m_left == 0) m_shown = m_pend;
            end
         end
      end
   end

   // Continuous comparison on the falling edge, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            int i5, i4;
            i5 = (m_cycles / RD) % 5;
            i4 = (m_cycles / RD) % 4;
            check("en5",   32'(en5),   32'(1 << i5));
            check("seg5",  32'(seg5),  32'(exp_seg(m_shown, i5, 5, 1'b1)));
            check("busy5", 32'(busy5), 32'(m_left > 0));
            check("ovf5",  32'(ovf5),  32'(m_shown >= 100000));
            check("enn",   32'(enn),   32'(1 << i5));
            check("segn",  32'(segn),  32'(exp_seg(m_shown, i5, 5, 1'b0)));
            check("busyn", 32'(busyn), 32'(m_left > 0));
            check("ovfn",  32'(ovfn),  32'(m_shown >= 100000));
            check("en4",   32'(en4),   32'(1 << i4));
            check("seg4",  32'(seg4),  32'(exp_seg(m_shown, i4, 4, 1'b1)));
            check("busy4", 32'(busy4), 32'(m_left > 0));
            check("ovf4",  32'(ovf4),  32'(m_shown >= 10000));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int v);
      load  = 1'b1;
      value = DW'(v);
      tick(1);
      load  = 1'b0;
   endtask

   // Walk the scan on a 5-digit instance (0 = blanked, 1 = unblanked) against literal patterns
   task automatic scan5(input string tag, input int which, input logic [0:6] e0, input logic [0:6] e1,
                        input logic [0:6] e2, input logic [0:6] e3, input logic [0:6] e4);
      logic [0:6] e [5];
      e = '{e0, e1, e2, e3, e4};
      for (int i = 0; i < 5; i++) begin
         int t;
         t = 0;
         while (((which == 0) ? en5 : enn) !== 5'(1 << i) && t < 40) begin
            tick(1);
            t++;
         end
         check({tag, "_en"}, 32'((which == 0) ? en5 : enn), 32'(1 << i));
         check(tag, 32'((which == 0) ? seg5 : segn), 32'(e[i]));
      end
   endtask

   function automatic int pick_value();
      case ($urandom % 6)
         0: return 0;
         1: return 9999 + int'($urandom % 2);
         2: return 65535;
         3: return 99999 % 65536;
         default: return int'($urandom % 65536);
      endcase
   endfunction

   initial begin
      int bc;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      chk_on = 1'b1;
      check("rst_en",   32'(en5),   32'(5'b00001));
      check("rst_seg",  32'(seg5),  32'(7'b1111110));
      check("rst_busy", 32'(busy5), 32'(0));

      // digit_en rotation and wrap back to digit 0 after five dwell periods
      tick(RD * 4);
      check("rot_last", 32'(en5), 32'(5'b10000));
      tick(RD);
      check("rot_wrap", 32'(en5), 32'(5'b00001));

      // 12345: busy length and per-digit patterns
      do_load(12345);
      bc = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy5) bc++;
         tick(1);
      end
      check("busy_len", 32'(bc), 32'(17));
      scan5("d12345", 0, 7'b1011011, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);

      // 7 with and without leading-zero blanking
      do_load(7);
      tick(20);
      scan5("d7_blank", 0, 7'b1110000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);
      scan5("d7_zeros", 1, 7'b1110000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);

      // overflow on the 4-digit instance, then the largest 4-digit value
      do_load(65535);
      tick(20);
      check("ovf4_set", 32'(ovf4), 32'(1));
      check("ovf5_clr", 32'(ovf5), 32'(0));
      do_load(9999);
      tick(20);
      check("ovf4_clr", 32'(ovf4), 32'(0));

      // loads during conversion ignored; load in the cycle busy falls accepted
      do_load(500);
      tick(2);
      do_load(42);
      tick(6);
      do_load(42);
      tick(7);
      check("busy_fell", 32'(busy5), 32'(0));
      do_load(42);
      check("busy_again", 32'(busy5), 32'(1));
      tick(20);

      // randomized loads, many landing while busy
      for (int k = 0; k < 400; k++) begin
         load  = ($urandom % 6 == 0);
         value = DW'(pick_value());
         tick(1);
      end
      load = 1'b0;
      tick(25);

      // reset in the middle of converting 60000
      do_load(60000);
      tick(7);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy5), 32'(0));
      check("mid_rst_en",   32'(en5),   32'(5'b00001));
      check("mid_rst_seg",  32'(seg5),  32'(7'b1111110));
      check("mid_rst_ovf4", 32'(ovf4),  32'(0));
      tick(2);
      rst_n = 1'b1;
      tick(40);
      check("post_rst_busy", 32'(busy5), 32'(0));

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
